// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with an IR, IDCODE, BYPASS and one user data register.
// The user register exposes capture/update strobes for on-chip debug logic.
module jtag_tap_ctrl #(
  parameter int unsigned     IR_W       = 5,
  parameter int unsigned     DR_W       = 32,
  parameter logic [31:0]     IDCODE_VAL = 32'hDEB1_1001,
  parameter logic [IR_W-1:0] IR_IDCODE  = 5'h01,
  parameter logic [IR_W-1:0] IR_USER    = 5'h11
) (
  input  logic            tck,
  input  logic            trst_n,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir_q,
  output logic            usr_capture,
  input  logic [DR_W-1:0] usr_capture_data,
  output logic            usr_update,
  output logic [DR_W-1:0] usr_update_data
);

  typedef enum logic [3:0] {
    StTlr   = 4'd0,
    StRti   = 4'd1,
    StSelDr = 4'd2,
    StCapDr = 4'd3,
    StShDr  = 4'd4,
    StEx1Dr = 4'd5,
    StPauDr = 4'd6,
    StEx2Dr = 4'd7,
    StUpdDr = 4'd8,
    StSelIr = 4'd9,
    StCapIr = 4'd10,
    StShIr  = 4'd11,
    StEx1Ir = 4'd12,
    StPauIr = 4'd13,
    StEx2Ir = 4'd14,
    StUpdIr = 4'd15
  } tap_state_e;

  // Capture pattern for the IR: ...0001, LSB pair fixed at 2'b01.
  localparam logic [IR_W-1:0] IrCapture = IR_W'(1);

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_shift_q;
  logic [IR_W-1:0] ir_reg_q;
  logic [31:0]     idcode_shift_q;
  logic [DR_W-1:0] usr_shift_q;
  logic            bypass_q;
  logic [DR_W-1:0] usr_update_data_q;
  logic            usr_capture_q;
  logic            usr_update_q;
  logic            tdo_q;
  logic            tdo_en_q;

  logic sel_idcode;
  logic sel_user;
  logic dr_lsb;
  logic shifting;
  logic tdo_d;

  assign sel_idcode = (ir_reg_q == IR_IDCODE);
  // Any opcode that is neither IDCODE nor USER (including all ones) selects BYPASS.
  assign sel_user   = (ir_reg_q == IR_USER) && !sel_idcode;

  // Next-state decode of the 16-state TAP machine from tms.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = tms ? StTlr   : StRti;
      StRti:   state_d = tms ? StSelDr : StRti;
      StSelDr: state_d = tms ? StSelIr : StCapDr;
      StCapDr: state_d = tms ? StEx1Dr : StShDr;
      StShDr:  state_d = tms ? StEx1Dr : StShDr;
      StEx1Dr: state_d = tms ? StUpdDr : StPauDr;
      StPauDr: state_d = tms ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = tms ? StUpdDr : StShDr;
      StUpdDr: state_d = tms ? StSelDr : StRti;
      StSelIr: state_d = tms ? StTlr   : StCapIr;
      StCapIr: state_d = tms ? StEx1Ir : StShIr;
      StShIr:  state_d = tms ? StEx1Ir : StShIr;
      StEx1Ir: state_d = tms ? StUpdIr : StPauIr;
      StPauIr: state_d = tms ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = tms ? StUpdIr : StShIr;
      StUpdIr: state_d = tms ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  // TAP state register.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  // IR shift register and current instruction; entry into TLR restores defaults.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_shift_q <= '0;
      ir_reg_q   <= IR_IDCODE;
    end else if (state_d == StTlr) begin
      ir_shift_q <= '0;
      ir_reg_q   <= IR_IDCODE;
    end else begin
      if (state_q == StCapIr) begin
        ir_shift_q <= IrCapture;
      end else if (state_q == StShIr) begin
        ir_shift_q <= {tdi, ir_shift_q[IR_W-1:1]};
      end
      // Load on entry so the new instruction is visible during Update-IR.
      if (state_d == StUpdIr) begin
        ir_reg_q <= ir_shift_q;
      end
    end
  end

  // Data registers: only the register selected by the instruction captures or shifts.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idcode_shift_q <= '0;
      usr_shift_q    <= '0;
      bypass_q       <= 1'b0;
    end else if (state_d == StTlr) begin
      bypass_q <= 1'b0;
    end else if (state_q == StCapDr) begin
      if (sel_idcode) begin
        idcode_shift_q <= IDCODE_VAL;
      end else if (sel_user) begin
        usr_shift_q <= usr_capture_data;
      end else begin
        bypass_q <= 1'b0;
      end
    end else if (state_q == StShDr) begin
      if (sel_idcode) begin
        idcode_shift_q <= {tdi, idcode_shift_q[31:1]};
      end else if (sel_user) begin
        usr_shift_q <= {tdi, usr_shift_q[DR_W-1:1]};
      end else begin
        bypass_q <= tdi;
      end
    end
  end

  // User update latch, loaded on entry to Update-DR so data and strobe align.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      usr_update_data_q <= '0;
    end else if (state_d == StTlr) begin
      usr_update_data_q <= '0;
    end else if ((state_d == StUpdDr) && sel_user) begin
      usr_update_data_q <= usr_shift_q;
    end
  end

  // Strobes registered from the next-state decode: glitch-free, high for the whole state.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      usr_capture_q <= 1'b0;
      usr_update_q  <= 1'b0;
    end else begin
      usr_capture_q <= (state_d == StCapDr) && sel_user;
      usr_update_q  <= (state_d == StUpdDr) && sel_user;
    end
  end

  // Serial output selection for the current shift state.
  always_comb begin
    dr_lsb   = bypass_q;
    shifting = 1'b0;
    tdo_d    = 1'b0;
    if (sel_idcode) begin
      dr_lsb = idcode_shift_q[0];
    end else if (sel_user) begin
      dr_lsb = usr_shift_q[0];
    end
    if (state_q == StShDr) begin
      shifting = 1'b1;
      tdo_d    = dr_lsb;
    end else if (state_q == StShIr) begin
      shifting = 1'b1;
      tdo_d    = ir_shift_q[0];
    end
  end

  // tdo changes on the falling edge so it is stable at the driver's rising-edge sample.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= shifting;
    end
  end

  assign tdo             = tdo_q;
  assign tdo_en          = tdo_en_q;
  assign tap_state       = state_q;
  assign ir_q            = ir_reg_q;
  assign usr_capture     = usr_capture_q;
  assign usr_update      = usr_update_q;
  assign usr_update_data = usr_update_data_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized self-checking bench for jtag_tap_ctrl against a scan-level reference model.
module tb_jtag_tap_ctrl;

  localparam int unsigned IR_W   = 5;
  localparam int unsigned DR_W   = 32;
  localparam logic [31:0] IDC    = 32'hDEB1_1001;
  localparam logic [4:0]  IR_IDC = 5'h01;
  localparam logic [4:0]  IR_USR = 5'h11;

  logic            tck;
  logic            trst_n;
  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] ir_q;
  logic            usr_capture;
  logic [DR_W-1:0] usr_capture_data;
  logic            usr_update;
  logic [DR_W-1:0] usr_update_data;

  jtag_tap_ctrl #(
    .IR_W      (IR_W),
    .DR_W      (DR_W),
    .IDCODE_VAL(IDC),
    .IR_IDCODE (IR_IDC),
    .IR_USER   (IR_USR)
  ) dut (
    .tck             (tck),
    .trst_n          (trst_n),
    .tms             (tms),
    .tdi             (tdi),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .tap_state       (tap_state),
    .ir_q            (ir_q),
    .usr_capture     (usr_capture),
    .usr_capture_data(usr_capture_data),
    .usr_update      (usr_update),
    .usr_update_data (usr_update_data)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  // IEEE 1149.1 transition table indexed by state code, for tms=0 and tms=1.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int         model_state;
  logic [4:0] model_ir;
  int         cap_cnt  = 0;
  int         upd_cnt  = 0;
  int         both_cnt = 0;

  // A one-period strobe spans exactly one falling edge.
  always @(negedge tck) begin
    if (usr_capture) cap_cnt++;
    if (usr_update) upd_cnt++;
    if (usr_capture && usr_update) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One TCK: drive tms/tdi while tck is low, return tdo as seen by the rising edge.
  task automatic tick(input logic m, input logic d, output logic o);
    bit in_shift;
    in_shift = (model_state == 4) || (model_state == 11);
    tms = m;
    tdi = d;
    o   = tdo;
    check_eq("tdo_en", tdo_en, in_shift);
    if (!in_shift) check_eq("tdo_idle", tdo, 1'b0);
    @(posedge tck);
    model_state = m ? nxt1[model_state] : nxt0[model_state];
    if (model_state == 0) model_ir = IR_IDC;
    @(negedge tck);
    #1;
    check_eq("tap_state", tap_state, model_state);
  endtask

  function automatic int dr_width(input logic [4:0] ir);
    if (ir == IR_IDC) return 32;
    if (ir == IR_USR) return DR_W;
    return 1;
  endfunction

  // Full scan from RTI back to RTI. The register stream is capture value followed by tdi bits:
  // bit i of tdo equals stream bit i, and the register ends holding stream bits [n +: width].
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din, input int pause_at,
                      input logic [31:0] capv);
    logic [127:0] s, out, mask_n, mask_w, fin;
    logic [31:0]  capval;
    int           w, c0, u0;
    bit           is_usr;
    logic         o;
    is_usr = !is_ir && (model_ir == IR_USR);
    usr_capture_data = capv;
    if (is_ir) begin
      w = IR_W; capval = 32'd1;
    end else begin
      w = dr_width(model_ir);
      capval = (model_ir == IR_IDC) ? IDC : (is_usr ? capv : 32'd0);
    end
    mask_w = (128'd1 << w) - 128'd1;
    mask_n = (128'd1 << n) - 128'd1;
    s   = (128'(capval) & mask_w) | (128'(din) << w);
    fin = (s >> n) & mask_w;
    out = '0;
    c0  = cap_cnt;
    u0  = upd_cnt;
    tick(1'b1, 1'b0, o);
    if (is_ir) tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    if (!is_ir) check_eq("usr_capture_lvl", usr_capture, is_usr);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      bit last, pz;
      last = (i == n - 1);
      pz   = (i == pause_at - 1) && !last;
      tick(last || pz, din[i], o);
      out[i] = o;
      if (pz) begin
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, o);
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
      end
    end
    tick(1'b1, 1'b0, o);
    if (!is_ir) begin
      check_eq("usr_update_lvl", usr_update, is_usr);
      if (is_usr) check_eq("upd_data_in_upd", usr_update_data, fin);
    end
    tick(1'b0, 1'b0, o);
    check_eq("tdo_stream", out & mask_n, s & mask_n);
    check_eq("back_to_rti", tap_state, 4'd1);
    if (is_ir) begin
      model_ir = fin[4:0];
      check_eq("ir_q", ir_q, model_ir);
    end else begin
      check_eq("capture_pulses", cap_cnt - c0, is_usr ? 1 : 0);
      check_eq("update_pulses", upd_cnt - u0, is_usr ? 1 : 0);
      if (is_usr) check_eq("usr_update_data", usr_update_data, fin);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        o;
    logic [31:0] r;
    logic [4:0]  irv;
    int          n, steps, u0;

    trst_n = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    usr_capture_data = '0;
    model_state = 0;
    model_ir = IR_IDC;
    #1 trst_n = 1'b0;
    #2;
    check_eq("rst_state", tap_state, 4'd0);
    check_eq("rst_ir", ir_q, IR_IDC);
    check_eq("rst_tdo", tdo, 1'b0);
    check_eq("rst_tdo_en", tdo_en, 1'b0);
    check_eq("rst_upd_data", usr_update_data, 32'd0);
    check_eq("rst_strobes", {usr_capture, usr_update}, 2'b00);
    @(negedge tck);
    #1 trst_n = 1'b1;

    tick(1'b0, 1'b0, o);
    scan(1'b0, 32, 64'd0, 0, 32'd0);
    scan(1'b1, 5, 64'h1F, 0, 32'd0);
    scan(1'b0, 9, 64'h0A5, 0, 32'd0);
    scan(1'b1, 5, 64'h11, 0, 32'd0);
    scan(1'b0, 32, 64'hCAFE_F00D, 0, 32'h1234_5678);
    scan(1'b0, 32, 64'hCAFE_F00D, 16, 32'h1234_5678);
    check_eq("pause_same_data", usr_update_data, 32'hCAFE_F00D);

    for (int it = 0; it < 24; it++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0:       irv = IR_IDC;
        1:       irv = IR_USR;
        default: irv = r[4:0];
      endcase
      scan(1'b1, 5, 64'(irv), $urandom_range(0, 4), 32'd0);
      n = (dr_width(model_ir) == 1) ? int'($urandom_range(1, 16)) : dr_width(model_ir);
      scan(1'b0, n, {$urandom, $urandom}, $urandom_range(0, n - 1), $urandom);
    end

    // Reset in the middle of a user-register shift.
    scan(1'b1, 5, 64'(IR_USR), 0, 32'd0);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom), o);
    u0 = upd_cnt;
    trst_n = 1'b0;
    #1;
    model_state = 0;
    model_ir = IR_IDC;
    check_eq("midrst_state", tap_state, 4'd0);
    check_eq("midrst_ir", ir_q, IR_IDC);
    check_eq("midrst_upd", usr_update, 1'b0);
    check_eq("midrst_upd_data", usr_update_data, 32'd0);
    check_eq("midrst_tdo_en", tdo_en, 1'b0);
    repeat (2) @(negedge tck);
    #1 trst_n = 1'b1;
    tick(1'b0, 1'b0, o);
    check_eq("midrst_no_update", upd_cnt - u0, 0);
    scan(1'b0, 32, {$urandom, $urandom}, 0, 32'd0);

    // From each state, five tms=1 edges reach TLR.
    for (int st = 0; st < 16; st++) begin
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, o);
      steps = 0;
      while (model_state != st && steps < 400) begin
        tick(1'($urandom), 1'($urandom), o);
        steps++;
      end
      check_eq("walk_reach", model_state, st);
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, o);
      check_eq("tlr_after5", tap_state, 4'd0);
      check_eq("tlr_ir", ir_q, IR_IDC);
    end

    check_eq("strobes_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
